// File: rtl/matrix_frame_ctrl.sv
// ---------------------------------------------------------------------------
// matrix_frame_ctrl
//
// Frame controller for an 8x8 LED matrix scan driver. The MCU writes row
// bytes into a back buffer. A swap request publishes the back buffer to the
// front buffer at the next frame boundary, so a frame is never torn. A
// prescaler, a 16-step sub-step counter and a row counter pace the scan. The
// driver output enable is gated by a brightness compare on the sub-step.
//
// Optional feature (macro MATRIX_FRAME_CTRL_BLINK_EN):
//   Adds the input 'blink' and a 5-bit frame counter. While blink = 1 and
//   frame counter bit 4 = 1, drv_oe is forced low. This gives a 32-frame blink
//   period at 50% duty.
//
// Ports:
//   clock        in   system clock
//   reset_n      in   asynchronous active-low reset
//   enable       in   1 = scan runs; 0 = scan held at 0 and outputs blanked
//   wr_en        in   back-buffer byte write strobe
//   wr_addr[2:0] in   row index of the write (row r = bits [8r+7:8r])
//   wr_data[7:0] in   column byte of the write
//   swap_req     in   request to publish the back buffer at the next frame end
//   brightness   in   on-time in sub-steps per row slot (0..15)
//   blink        in   (BLINK_EN only) blink gate enable
//   swap_pending out  swap requested, not yet performed
//   swap_done    out  one-cycle pulse when the front buffer takes the new frame
//   drv_data     out  front buffer contents (64 bits)
//   drv_oe       out  driver output enable
//   row_idx      out  row slot being scanned
//   frame_end    out  one-cycle pulse on the last cycle of row slot 7
// ---------------------------------------------------------------------------
module matrix_frame_ctrl #(
    parameter int PRESCALE = 64,
    parameter int ROWS     = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        swap_req,
    input  logic [3:0]  brightness,
`ifdef MATRIX_FRAME_CTRL_BLINK_EN
    input  logic        blink,
`endif
    output logic        swap_pending,
    output logic        swap_done,
    output logic [63:0] drv_data,
    output logic        drv_oe,
    output logic [2:0]  row_idx,
    output logic        frame_end
);

    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [2:0]    ROW_LAST = 3'(ROWS - 1);

    // run_r marks cycles in which the scan counters are live. It lags enable
    // by one cycle, so a scan always starts from all-zero counters in the
    // cycle after enable rises.
    logic          run_r;
    logic [PW-1:0] pre_r;
    logic [3:0]    sub_r;
    logic [2:0]    row_r;
    logic [63:0]   back_r;
    logic [63:0]   front_r;
    logic          pending_r;
    logic          done_r;
    logic          oe_r;
    logic          fe_r;

    logic [PW-1:0] pre_n_s;
    logic [3:0]    sub_n_s;
    logic [2:0]    row_n_s;
    logic          fe_n_s;
    logic          oe_n_s;
    logic          swap_fire_s;
    logic          pending_n_s;
    logic          blank_s;

`ifdef MATRIX_FRAME_CTRL_BLINK_EN
    logic [4:0] fcnt_r;
    logic [4:0] fcnt_n_s;

    // Frame counter advance and blink blanking decision for the next cycle.
    always_comb begin
        fcnt_n_s = fcnt_r + {4'd0, fe_r};
        blank_s  = blink & fcnt_n_s[4];
    end

    // Frame counter register: counts frame_end pulses and wraps at 32.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fcnt_r <= 5'd0;
        end else begin
            fcnt_r <= fcnt_n_s;
        end
    end
`else
    assign blank_s = 1'b0;
`endif

    // Next values of the scan timing chain, held at zero while not running.
    always_comb begin
        pre_n_s = {PW{1'b0}};
        sub_n_s = 4'd0;
        row_n_s = 3'd0;
        if (!enable || !run_r) begin
            pre_n_s = {PW{1'b0}};
            sub_n_s = 4'd0;
            row_n_s = 3'd0;
        end else if (pre_r == PRE_LAST) begin
            pre_n_s = {PW{1'b0}};
            if (sub_r == 4'd15) begin
                sub_n_s = 4'd0;
                row_n_s = (row_r == ROW_LAST) ? 3'd0 : row_r + 3'd1;
            end else begin
                sub_n_s = sub_r + 4'd1;
                row_n_s = row_r;
            end
        end else begin
            pre_n_s = pre_r + {{(PW-1){1'b0}}, 1'b1};
            sub_n_s = sub_r;
            row_n_s = row_r;
        end
    end

    // Registered outputs look one cycle ahead, so drv_oe and frame_end line
    // up with the counter values they describe.
    always_comb begin
        fe_n_s      = enable & (pre_n_s == PRE_LAST) & (sub_n_s == 4'd15)
                      & (row_n_s == ROW_LAST);
        oe_n_s      = enable & (sub_n_s < brightness) & ~blank_s;
        swap_fire_s = fe_r & pending_r;
        // A request in the completing cycle re-arms for the next frame.
        if (swap_req) begin
            pending_n_s = 1'b1;
        end else if (swap_fire_s) begin
            pending_n_s = 1'b0;
        end else begin
            pending_n_s = pending_r;
        end
    end

    // Scan counters, frame buffers and the swap handshake state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_r     <= 1'b0;
            pre_r     <= {PW{1'b0}};
            sub_r     <= 4'd0;
            row_r     <= 3'd0;
            back_r    <= 64'd0;
            front_r   <= 64'd0;
            pending_r <= 1'b0;
            done_r    <= 1'b0;
            oe_r      <= 1'b0;
            fe_r      <= 1'b0;
        end else begin
            run_r     <= enable;
            pre_r     <= pre_n_s;
            sub_r     <= sub_n_s;
            row_r     <= row_n_s;
            oe_r      <= oe_n_s;
            fe_r      <= fe_n_s;
            pending_r <= pending_n_s;
            done_r    <= swap_fire_s;
            // front takes the pre-write back value when a write coincides.
            if (swap_fire_s) begin
                front_r <= back_r;
            end
            if (wr_en) begin
                back_r[{wr_addr, 3'b000} +: 8] <= wr_data;
            end
        end
    end

    assign swap_pending = pending_r;
    assign swap_done    = done_r;
    assign drv_data     = front_r;
    assign drv_oe       = oe_r;
    assign row_idx      = row_r;
    assign frame_end    = fe_r;

endmodule

// File: tb/tb_matrix_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_matrix_frame_ctrl
//
// Self-checking bench for matrix_frame_ctrl (PRESCALE = 2). The reference
// model tracks scan position as "cycles since the scan started" and derives
// row, sub-step and frame boundary from it arithmetically. Frame buffers are
// kept as a byte array. Directed phases follow the test plan, and a
// randomized phase exercises writes, swaps, brightness and enable together.
// ---------------------------------------------------------------------------
module tb_matrix_frame_ctrl;

    localparam int P     = 2;
    localparam int SLOT  = 16 * P;
    localparam int FRAME = 8 * SLOT;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        swap_req;
    logic [3:0]  brightness;
`ifdef MATRIX_FRAME_CTRL_BLINK_EN
    logic        blink;
`endif
    logic        swap_pending;
    logic        swap_done;
    logic [63:0] drv_data;
    logic        drv_oe;
    logic [2:0]  row_idx;
    logic        frame_end;

    matrix_frame_ctrl #(.PRESCALE(P), .ROWS(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .swap_req     (swap_req),
        .brightness   (brightness),
`ifdef MATRIX_FRAME_CTRL_BLINK_EN
        .blink        (blink),
`endif
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .drv_data     (drv_data),
        .drv_oe       (drv_oe),
        .row_idx      (row_idx),
        .frame_end    (frame_end)
    );

    always #5 clock = ~clock;

    int total;
    int bad;

    // reference model state, describing the currently observed cycle
    logic [7:0]  m_back [8];
    logic [63:0] m_front;
    logic        m_pending;
    logic        m_done;
    logic        m_run;
    int          m_pos;
    logic [3:0]  m_bprev;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_pack();
        logic [63:0] v;
        v = 64'd0;
        for (int r = 0; r < 8; r++) v[8*r +: 8] = m_back[r];
        return v;
    endfunction

    function automatic logic m_fe();
        return m_run && ((m_pos % FRAME) == FRAME - 1);
    endfunction

    function automatic logic m_oe();
        return m_run && (((m_pos / P) % 16) < int'(m_bprev));
    endfunction

    function automatic logic [2:0] m_row();
        return m_run ? 3'((m_pos / SLOT) % 8) : 3'd0;
    endfunction

    task automatic m_clear();
        for (int r = 0; r < 8; r++) m_back[r] = 8'd0;
        m_front   = 64'd0;
        m_pending = 1'b0;
        m_done    = 1'b0;
        m_run     = 1'b0;
        m_pos     = 0;
        m_bprev   = 4'd0;
    endtask

    // advance the model across one clock edge using the applied inputs
    task automatic m_step();
        logic fire;
        fire = m_fe() && m_pending;
        if (fire) m_front = m_pack();
        if (wr_en) m_back[wr_addr] = wr_data;
        m_pending = swap_req ? 1'b1 : (fire ? 1'b0 : m_pending);
        m_done    = fire;
        if (enable && m_run) m_pos = m_pos + 1;
        else                 m_pos = 0;
        m_run   = enable;
        m_bprev = brightness;
    endtask

    task automatic compare_all();
        check_val("drv_data", drv_data, m_front);
        check_val("drv_oe", {63'd0, drv_oe}, {63'd0, m_oe()});
        check_val("row_idx", {61'd0, row_idx}, {61'd0, m_row()});
        check_val("frame_end", {63'd0, frame_end}, {63'd0, m_fe()});
        check_val("swap_done", {63'd0, swap_done}, {63'd0, m_done});
        check_val("swap_pending", {63'd0, swap_pending}, {63'd0, m_pending});
    endtask

    // drive one cycle of inputs (from a negedge), clock it, check next cycle
    task automatic cycle(input logic en, input logic we, input logic [2:0] wa,
                         input logic [7:0] wd, input logic sr, input logic [3:0] br);
        enable     = en;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        swap_req   = sr;
        brightness = br;
        @(posedge clock);
        m_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic align_frame_end(input logic [3:0] br);
        int guard;
        guard = 0;
        while (!m_fe() && guard < 2 * FRAME) begin
            cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, br);
            guard++;
        end
        check_val("align_fe", {63'd0, frame_end}, 64'd1);
    endtask

    task automatic reset_check();
        check_val("rst_data", drv_data, 64'd0);
        check_val("rst_oe", {63'd0, drv_oe}, 64'd0);
        check_val("rst_row", {61'd0, row_idx}, 64'd0);
        check_val("rst_fe", {63'd0, frame_end}, 64'd0);
        check_val("rst_done", {63'd0, swap_done}, 64'd0);
        check_val("rst_pend", {63'd0, swap_pending}, 64'd0);
    endtask

    int oe_cnt;
    int fe_cnt;
    int done_cnt;
    int k;
    logic found;
    logic en_r;
    logic [3:0] br_r;

    initial begin
        total = 0;
        bad = 0;
        clock = 1'b0;
        reset_n = 1'b0;
        enable = 1'b0;
        wr_en = 1'b0;
        wr_addr = 3'd0;
        wr_data = 8'd0;
        swap_req = 1'b0;
        brightness = 4'd0;
`ifdef MATRIX_FRAME_CTRL_BLINK_EN
        blink = 1'b0;
`endif
        m_clear();
        repeat (3) @(negedge clock);
        reset_check();
        reset_n = 1'b1;

        // rows 0..7 = 0x01..0x80 without a swap: front stays 0
        for (int r = 0; r < 8; r++) cycle(1'b1, 1'b1, 3'(r), 8'(1 << r), 1'b0, 4'd4);
        repeat (300) cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 4'd4);
        check_val("noswap_data", drv_data, 64'd0);
        check_val("noswap_pend", {63'd0, swap_pending}, 64'd0);

        // mid-frame swap: exactly one swap_done, pattern published
        cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 4'd4);
        check_val("swap_pend_set", {63'd0, swap_pending}, 64'd1);
        done_cnt = 0;
        repeat (300) begin
            cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 4'd4);
            if (swap_done) done_cnt++;
        end
        check_val("swap_done_cnt", 64'(done_cnt), 64'd1);
        check_val("swap_data", drv_data, 64'h8040201008040201);
        check_val("swap_pend_clr", {63'd0, swap_pending}, 64'd0);

        // duty and frame rate over one aligned frame, brightness 4 then 0
        align_frame_end(4'd4);
        oe_cnt = 0;
        fe_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 4'd4);
            if (drv_oe) oe_cnt++;
            if (frame_end) fe_cnt++;
            if (i % SLOT < 8) check_val("oe_on_slot", {63'd0, drv_oe}, 64'd1);
        end
        check_val("oe_cnt_b4", 64'(oe_cnt), 64'd64);
        check_val("fe_cnt", 64'(fe_cnt), 64'd1);
        oe_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 4'd0);
            if (drv_oe) oe_cnt++;
        end
        check_val("oe_cnt_b0", 64'(oe_cnt), 64'd0);

        // write coinciding with a completing swap
        cycle(1'b1, 1'b1, 3'd3, 8'h55, 1'b1, 4'd4);
        align_frame_end(4'd4);
        cycle(1'b1, 1'b1, 3'd3, 8'hAA, 1'b0, 4'd4);
        check_val("coinc_done", {63'd0, swap_done}, 64'd1);
        check_val("coinc_row3", {56'd0, drv_data[31:24]}, 64'h55);
        cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 4'd4);
        repeat (300) cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 4'd4);
        check_val("second_row3", {56'd0, drv_data[31:24]}, 64'hAA);

        // enable dropped with a swap pending, then resumed
        repeat (40) cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 4'd9);
        cycle(1'b0, 1'b1, 3'd5, 8'h3C, 1'b1, 4'd9);
        repeat (50) cycle(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 4'd9);
        check_val("dis_oe", {63'd0, drv_oe}, 64'd0);
        check_val("dis_row", {61'd0, row_idx}, 64'd0);
        check_val("dis_pend", {63'd0, swap_pending}, 64'd1);
        k = 0;
        found = 1'b0;
        while (!found && k < 400) begin
            k++;
            cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 4'd9);
            if (swap_done) found = 1'b1;
        end
        check_val("reen_latency", 64'(k - 1), 64'(FRAME));
        check_val("reen_row5", {56'd0, drv_data[47:40]}, 64'h3C);

        // randomized traffic
        en_r = 1'b1;
        br_r = 4'd7;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) en_r = ~en_r;
            if ($urandom_range(0, 49) == 0) br_r = 4'($urandom_range(0, 15));
            cycle(en_r, 1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 59) == 0), br_r);
        end

        // reset mid-slot with a swap pending
        cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 4'd15);
        repeat (21) cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 4'd15);
        reset_n = 1'b0;
        #1;
        reset_check();
        m_clear();
        @(negedge clock);
        reset_n = 1'b1;
        cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 4'd15);
        check_val("post_rst_pend", {63'd0, swap_pending}, 64'd0);
        repeat (20) cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 4'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
